store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 143 ++++++++++++++
 tb/tb_store_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: DEPTH-entry FIFO of {addr, data, strb} drained one write at a time over a req/ack port.
// Optional load forwarding is compiled in with `define STORE_BUF_FWD_EN.
module store_buffer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       st_valid,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [DATA_W-1:0]          st_data,
   input  logic [DATA_W/8-1:0]        st_strb,
   output logic                       st_ready,
   output logic                       mem_req,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_data,
   output logic [DATA_W/8-1:0]        mem_strb,
   input  logic                       mem_ack,
   output logic                       busy,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   input  logic [ADDR_W-1:0]          ld_addr,
   output logic                       fwd_hit,
   output logic [DATA_W-1:0]          fwd_data,
   output logic [DATA_W/8-1:0]        fwd_strb
);

   // state | meaning
   // IDLE  | no write outstanding; loads the head entry onto mem_* when not empty
   // REQ   | mem_req high, payload held until mem_ack pops the head
   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   localparam int STRB_W = DATA_W / 8;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [STRB_W-1:0] strb_mem [DEPTH];

   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;
   state_t            state_q, state_d;
   logic              push, pop, load;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign st_ready = !full;
   assign push     = st_valid && st_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!empty) state_d = REQ;
         REQ:     if (mem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req = (state_q == REQ);
      load    = (state_q == IDLE) && !empty;
      pop     = (state_q == REQ) && mem_ack;
      busy    = !empty || (state_q == REQ);
   end

   // Storage is not reset; only entries between head and tail are ever observed.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail_q] <= st_addr;
         data_mem[tail_q] <= st_data;
         strb_mem[tail_q] <= st_strb;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + PTR_W'(1);
         if (pop)  head_q <= head_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // The drained entry stays in the FIFO until acked, so the payload is a copy of the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr <= '0;
         mem_data <= '0;
         mem_strb <= '0;
      end else if (load) begin
         mem_addr <= addr_mem[head_q];
         mem_data <= data_mem[head_q];
         mem_strb <= strb_mem[head_q];
      end
   end

`ifdef STORE_BUF_FWD_EN
   logic [PTR_W-1:0] fwd_idx;

   // Scan oldest to youngest so the last match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_strb = '0;
      fwd_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (addr_mem[fwd_idx] == ld_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_mem[fwd_idx];
            fwd_strb = strb_mem[fwd_idx];
         end
      end
   end
`else
   logic unused_ld_addr;

   assign unused_ld_addr = ^ld_addr;
   assign fwd_hit        = 1'b0;
   assign fwd_data       = '0;
   assign fwd_strb       = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
   localparam int AW = 32, DW = 32, SW = 4, DEPTH = 4, CW = 3;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
   } ent_t;

   logic          clk, rst_n;
   logic          st_valid, st_ready;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_data;
   logic [SW-1:0] st_strb;
   logic          mem_req, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [SW-1:0] mem_strb;
   logic          busy, full, empty;
   logic [CW-1:0] count;
   logic [AW-1:0] ld_addr;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;
   logic [SW-1:0] fwd_strb;

   store_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_strb(st_strb),
      .st_ready(st_ready),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_strb(mem_strb),
      .mem_ack(mem_ack),
      .busy(busy), .full(full), .empty(empty), .count(count),
      .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_strb(fwd_strb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   failures = 0;
   bit   chk_en = 1'b0;
   bit   t6_done = 1'b0;
   ent_t mq[$];
   ent_t wr_log[$];
   bit   m_req = 1'b0;
   logic [DW-1:0] t6_data [10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference: pending stores in a queue; one outstanding write, one idle cycle after each ack.
   always @(posedge clk) begin : model
      bit   acc, nreq;
      ent_t e;
      if (rst_n) begin
         acc = st_valid && (mq.size() < DEPTH);
         if (m_req) nreq = !mem_ack;
         else       nreq = (mq.size() > 0);
         if (m_req && mem_ack) begin
            wr_log.push_back(mq[0]);
            void'(mq.pop_front());
         end
         if (acc) begin
            e.a = st_addr; e.d = st_data; e.s = st_strb;
            mq.push_back(e);
         end
         m_req = nreq;
      end
   end

   always @(negedge clk) begin : compare
      bit            hit;
      logic [DW-1:0] hd;
      logic [SW-1:0] hs;
      if (chk_en) begin
         chk("count", 64'(count), 64'(mq.size()));
         chk("empty", 64'(empty), 64'(mq.size() == 0));
         chk("full", 64'(full), 64'(mq.size() == DEPTH));
         chk("st_ready", 64'(st_ready), 64'(mq.size() < DEPTH));
         chk("mem_req", 64'(mem_req), 64'(m_req));
         chk("busy", 64'(busy), 64'(mq.size() > 0 || m_req));
         if (m_req && mq.size() > 0) begin
            chk("mem_addr", 64'(mem_addr), 64'(mq[0].a));
            chk("mem_data", 64'(mem_data), 64'(mq[0].d));
            chk("mem_strb", 64'(mem_strb), 64'(mq[0].s));
         end
         hit = 1'b0; hd = '0; hs = '0;
`ifdef STORE_BUF_FWD_EN
         foreach (mq[i]) if (mq[i].a == ld_addr) begin hit = 1'b1; hd = mq[i].d; hs = mq[i].s; end
`endif
         chk("fwd_hit", 64'(fwd_hit), 64'(hit));
         chk("fwd_data", 64'(fwd_data), 64'(hd));
         chk("fwd_strb", 64'(fwd_strb), 64'(hs));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; mq.delete(); m_req = 1'b0; wr_log.delete();
      st_valid = 1'b0; mem_ack = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      st_valid = 1'b1; st_addr = a; st_data = d; st_strb = s;
      tick();
      st_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      int c = 0;
      mem_ack = 1'b1;
      while (wr_log.size() < n && c < 100) begin tick(); c++; end
      mem_ack = 1'b0;
      if (wr_log.size() < n) chk("drain_timeout", 64'(wr_log.size()), 64'(n));
      tick(); tick();
   endtask

   initial begin
      rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_strb = '0;
      mem_ack = 1'b0; ld_addr = '0;
      #1 chk_en = 1'b1;
      #2;
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_st_ready", 64'(st_ready), 64'd1);
      do_reset();

      // single store latency and completion
      store(32'h100, 32'hDEADBEEF, 4'hF);
      chk("t1_req_after_E", 64'(mem_req), 64'd0);
      tick();
      chk("t1_req_after_E1", 64'(mem_req), 64'd1);
      chk("t1_addr", 64'(mem_addr), 64'h100);
      chk("t1_data", 64'(mem_data), 64'hDEADBEEF);
      chk("t1_strb", 64'(mem_strb), 64'hF);
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      chk("t1_empty", 64'(empty), 64'd1);
      chk("t1_busy", 64'(busy), 64'd0);
      tick();

      // fill to full, overflow dropped, ordered drain
      wr_log.delete();
      for (int i = 0; i < 4; i++) store(32'h10 + 32'(i * 4), 32'hA0 + 32'(i), 4'h3);
      chk("t2_full", 64'(full), 64'd1);
      chk("t2_st_ready", 64'(st_ready), 64'd0);
      store(32'h99, 32'h55, 4'hF);
      chk("t2_count_after_5th", 64'(count), 64'd4);
      drain(4);
      chk("t2_nwrites", 64'(wr_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++)
         chk("t2_order", 64'(wr_log[i].a), 64'(32'h10 + 32'(i * 4)));

      // full + simultaneous store and ack pops only
      wr_log.delete();
      for (int i = 0; i < 4; i++) store(32'h20 + 32'(i * 4), 32'hB0 + 32'(i), 4'hF);
      st_valid = 1'b1; st_addr = 32'h77; st_data = 32'h77; st_strb = 4'hF; mem_ack = 1'b1;
      tick();
      st_valid = 1'b0; mem_ack = 1'b0;
      chk("t3_count", 64'(count), 64'd3);
      drain(4);
      chk("t3_nwrites", 64'(wr_log.size()), 64'd4);
      foreach (wr_log[i]) if (wr_log[i].a == 32'h77) chk("t3_rejected_written", 64'(wr_log[i].a), 64'd0);

      // forwarding lookup
      store(32'h40, 32'h11, 4'h1);
      store(32'h40, 32'h22, 4'h2);
      ld_addr = 32'h40; #1;
`ifdef STORE_BUF_FWD_EN
      chk("t4_hit", 64'(fwd_hit), 64'd1);
      chk("t4_data", 64'(fwd_data), 64'h22);
`else
      chk("t4_hit_off", 64'(fwd_hit), 64'd0);
      chk("t4_data_off", 64'(fwd_data), 64'd0);
`endif
      ld_addr = 32'h44; #1;
      chk("t4_miss", 64'(fwd_hit), 64'd0);
      tick();
      wr_log.delete();
      drain(2);

      // reset while a write is outstanding
      for (int i = 0; i < 3; i++) store(32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 4'hF);
      chk("t5_req_before", 64'(mem_req), 64'd1);
      @(posedge clk); #2;
      rst_n = 1'b0; mq.delete(); m_req = 1'b0;
      #1;
      chk("t5_req_in_reset", 64'(mem_req), 64'd0);
      chk("t5_count_in_reset", 64'(count), 64'd0);
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("t5_no_write", 64'(mem_req), 64'd0);
      chk("t5_empty", 64'(empty), 64'd1);

      // 10 stores with random ack delay, pointer wrap
      wr_log.delete();
      fork
         begin
            bit acc;
            int tmo;
            for (int i = 0; i < 10; i++) begin
               st_valid = 1'b1; st_addr = 32'h200 + 32'(i * 4);
               st_data = $urandom; st_strb = 4'($urandom_range(1, 15));
               ld_addr = 32'h200 + 32'($urandom_range(0, 9) * 4);
               t6_data[i] = st_data;
               acc = 1'b0; tmo = 0;
               while (!acc && tmo < 200) begin
                  @(negedge clk); acc = st_ready;
                  tick(); tmo++;
               end
               if (!acc) chk("t6_accept_timeout", 64'd0, 64'd1);
               st_valid = 1'b0;
               if ($urandom_range(0, 1) == 1) tick();
            end
            begin
               int c = 0;
               while (wr_log.size() < 10 && c < 500) begin tick(); c++; end
            end
            t6_done = 1'b1;
         end
         begin
            int dly = -1;
            while (!t6_done) begin
               tick();
               mem_ack = 1'b0;
               if (mem_req) begin
                  if (dly < 0) dly = $urandom_range(0, 3);
                  if (dly == 0) begin mem_ack = 1'b1; dly = -1; end
                  else dly--;
               end else if ($urandom_range(0, 3) == 0) begin
                  mem_ack = 1'b1;
               end
            end
            mem_ack = 1'b0;
         end
      join
      tick(); tick();
      chk("t6_nwrites", 64'(wr_log.size()), 64'd10);
      for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
         chk("t6_addr", 64'(wr_log[i].a), 64'(32'h200 + 32'(i * 4)));
         chk("t6_data", 64'(wr_log[i].d), 64'(t6_data[i]));
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
